// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter: parity modes,
// serializer state encodings and counter-width helpers.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of an occupancy count that must hold 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: power-of-two depth, pointers wrap naturally, level never
// wraps because pushes are refused when full and pops when empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = idx_width(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Flags are registered from the next level so consumers see clean flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: FIFO-fed serializer producing
// start / data (LSB first) / optional parity / stop bits on a registered tx.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line high, waiting for a queued word (popped on exit)
// ST_START  | driving the start bit (0) for one bit time
// ST_DATA   | shifting DATA_BITS data bits out, LSB first
// ST_PARITY | driving the odd/even parity bit (skipped when PARITY=0)
// ST_STOP   | driving STOP_BITS stop bits; chains to START if FIFO not empty
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int BAUD_CNT   = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [8:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CW = idx_width(BAUD_CNT);
  localparam int BW = idx_width(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  tx_state_e            state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;

  logic [DATA_BITS-1:0] rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 baud_done;
  logic                 stop_last;
  logic                 par_calc;
  logic                 unused_upper;

  assign unused_upper = ^tx_data;
  assign tx_ready     = ~fifo_full;
  assign fifo_push    = tx_valid & tx_ready;
  assign baud_done    = (baud_cnt == BAUD_LAST);
  assign stop_last    = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign par_calc     = (PARITY == PAR_ODD) ? ~(^rd_data) : ^rd_data;

  // A word leaves the FIFO when idle, or at the very end of the last stop
  // bit so the next start bit follows with no gap.
  assign fifo_pop = ~fifo_empty &
                    ((state == ST_IDLE) |
                     ((state == ST_STOP) & baud_done & stop_last));

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (tx_data[DATA_BITS-1:0]),
    .pop     (fifo_pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // tx is registered from the current state's bit, so the line trails the
  // state by one clock uniformly; bit lengths and back-to-back spacing hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (state != ST_IDLE) baud_cnt <= baud_done ? '0 : baud_cnt + CW'(1);
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (fifo_pop) begin
            state     <= ST_START;
            busy      <= 1'b1;
            baud_cnt  <= '0;
            shift_reg <= rd_data;
            par_bit   <= par_calc;
          end
        end
        ST_START: begin
          tx <= 1'b0;
          if (baud_done) begin
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          tx <= shift_reg[0];
          if (baud_done) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + BW'(1);
            if (bit_idx == BIT_LAST) begin
              stop_idx <= 1'b0;
              state    <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          tx <= par_bit;
          if (baud_done) begin
            stop_idx <= 1'b0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          tx <= 1'b1;
          if (baud_done) begin
            if (!stop_last) begin
              stop_idx <= 1'b1;
            end else if (fifo_pop) begin
              state     <= ST_START;
              shift_reg <= rd_data;
              par_bit   <= par_calc;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
